// File: rtl/branch_target_buffer_if.sv
// Fetch-lookup and execute-update bundle for the branch target buffer.
// master = pipeline side (fetch + execute), slave = the BTB itself.
interface branch_target_buffer_if;
  logic [31:0] lookup_pc;
  logic        lookup_hit;
  logic        lookup_taken;
  logic [31:0] lookup_target;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        wrong_decision;
  logic [31:0] correct_pc;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  modport master (
    output lookup_pc, upd_en, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    input  lookup_hit, lookup_taken, lookup_target, wrong_decision,
           correct_pc, branch_count, mispredict_count
  );

  modport slave (
    input  lookup_pc, upd_en, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    output lookup_hit, lookup_taken, lookup_target, wrong_decision,
           correct_pc, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating counters and registered misprediction redirect.
// Optional statistics counters are generated only when BTB_STATS_EN is defined.
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input logic                   CLK,
  input logic                   RST,
  branch_target_buffer_if.slave bus
);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit, mispredict;
  logic [31:0]      redirect_pc;
  logic             wrong_decision_p1;
  logic [31:0]      correct_pc_p1;
  logic             unused_pc_lsbs;

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? 2'b11 : c + 2'b01;
    else    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign l_idx          = bus.lookup_pc[IDX_W+1:2];
  assign l_tag          = bus.lookup_pc[31:IDX_W+2];
  assign u_idx          = bus.upd_pc[IDX_W+1:2];
  assign u_tag          = bus.upd_pc[31:IDX_W+2];
  assign unused_pc_lsbs = ^bus.lookup_pc[1:0];

  // Lookup reads the array as it stands; an update on this edge is not bypassed.
  assign l_hit             = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign bus.lookup_hit    = l_hit;
  assign bus.lookup_taken  = l_hit && ctr_q[l_idx][1];
  assign bus.lookup_target = l_hit ? target_q[l_idx] : 32'd0;

  assign u_hit       = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign mispredict  = bus.upd_en &&
                       ((bus.upd_taken != bus.upd_pred_taken) ||
                        (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));
  assign redirect_pc = bus.upd_taken ? bus.upd_target : bus.upd_pc + 32'd4;

  // Stage p0 -> array: resolved-branch writeback
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b00;
      end
    end else if (bus.upd_en) begin
      if (u_hit) begin
        ctr_q[u_idx] <= ctr_next(ctr_q[u_idx], bus.upd_taken);
        if (bus.upd_taken) target_q[u_idx] <= bus.upd_target;
      end else if (bus.upd_taken) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= bus.upd_target;
        ctr_q[u_idx]    <= 2'b10;
      end
    end
  end

  // Stage p0 -> p1: registered redirect, pc held between mispredicts
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wrong_decision_p1 <= 1'b0;
      correct_pc_p1     <= 32'd0;
    end else begin
      wrong_decision_p1 <= mispredict;
      if (mispredict) correct_pc_p1 <= redirect_pc;
    end
  end

  assign bus.wrong_decision = wrong_decision_p1;
  assign bus.correct_pc     = correct_pc_p1;

`ifdef BTB_STATS_EN
  logic [15:0] branch_count_p1, mispredict_count_p1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      branch_count_p1     <= 16'd0;
      mispredict_count_p1 <= 16'd0;
    end else begin
      if (bus.upd_en) branch_count_p1     <= sat_inc16(branch_count_p1);
      if (mispredict) mispredict_count_p1 <= sat_inc16(mispredict_count_p1);
    end
  end

  assign bus.branch_count     = branch_count_p1;
  assign bus.mispredict_count = mispredict_count_p1;
`else
  logic unused_sat_fn;
  assign unused_sat_fn        = ^sat_inc16(16'd0);
  assign bus.branch_count     = 16'd0;
  assign bus.mispredict_count = 16'd0;
`endif
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: allocation, counter saturation, aliasing,
// misprediction redirect, back-to-back pulses, statistics and asynchronous reset.
module tb_branch_target_buffer;
  logic CLK, RST;
  int   n_cmp = 0;
  int   n_err = 0;

  branch_target_buffer_if bus_i ();

  branch_target_buffer #(.ENTRIES(16), .IDX_W(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_i)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
    bus_i.upd_en          = 1'b1;
    bus_i.upd_pc          = pc;
    bus_i.upd_taken       = tk;
    bus_i.upd_target      = tgt;
    bus_i.upd_pred_taken  = ptk;
    bus_i.upd_pred_target = ptgt;
  endtask

  task automatic idle();
    bus_i.upd_en          = 1'b0;
    bus_i.upd_pc          = 32'd0;
    bus_i.upd_taken       = 1'b0;
    bus_i.upd_target      = 32'd0;
    bus_i.upd_pred_taken  = 1'b0;
    bus_i.upd_pred_target = 32'd0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle();
    bus_i.lookup_pc = 32'h0000_0040;
    step(); step();
    n_cmp++; if (bus_i.lookup_hit !== 1'b0) begin n_err++; $display("FAIL rst_hit got=%0h exp=0", bus_i.lookup_hit); end
    n_cmp++; if (bus_i.lookup_taken !== 1'b0) begin n_err++; $display("FAIL rst_taken got=%0h exp=0", bus_i.lookup_taken); end
    n_cmp++; if (bus_i.lookup_target !== 32'd0) begin n_err++; $display("FAIL rst_target got=%h exp=0", bus_i.lookup_target); end
    n_cmp++; if (bus_i.wrong_decision !== 1'b0) begin n_err++; $display("FAIL rst_wd got=%0h exp=0", bus_i.wrong_decision); end
    n_cmp++; if (bus_i.correct_pc !== 32'd0) begin n_err++; $display("FAIL rst_cpc got=%h exp=0", bus_i.correct_pc); end
    @(negedge CLK);
    RST = 1'b0;
    step();
    n_cmp++; if (bus_i.lookup_hit !== 1'b0) begin n_err++; $display("FAIL post_rst_hit got=%0h exp=0", bus_i.lookup_hit); end
  endtask

  task automatic test_allocate();
    bus_i.lookup_pc = 32'h0000_0040;
    drive_upd(32'h0000_0040, 1'b1, 32'h0000_0100, 1'b0, 32'd0);
    #1;
    n_cmp++; if (bus_i.lookup_hit !== 1'b0) begin n_err++; $display("FAIL alloc_pre_hit got=%0h exp=0", bus_i.lookup_hit); end
    step();
    idle();
    n_cmp++; if (bus_i.wrong_decision !== 1'b1) begin n_err++; $display("FAIL alloc_wd got=%0h exp=1", bus_i.wrong_decision); end
    n_cmp++; if (bus_i.correct_pc !== 32'h100) begin n_err++; $display("FAIL alloc_cpc got=%h exp=00000100", bus_i.correct_pc); end
    n_cmp++; if (bus_i.lookup_hit !== 1'b1) begin n_err++; $display("FAIL alloc_hit got=%0h exp=1", bus_i.lookup_hit); end
    n_cmp++; if (bus_i.lookup_taken !== 1'b1) begin n_err++; $display("FAIL alloc_taken got=%0h exp=1", bus_i.lookup_taken); end
    n_cmp++; if (bus_i.lookup_target !== 32'h100) begin n_err++; $display("FAIL alloc_target got=%h exp=00000100", bus_i.lookup_target); end
    step();
    n_cmp++; if (bus_i.wrong_decision !== 1'b0) begin n_err++; $display("FAIL alloc_wd_drop got=%0h exp=0", bus_i.wrong_decision); end
    n_cmp++; if (bus_i.correct_pc !== 32'h100) begin n_err++; $display("FAIL alloc_cpc_hold got=%h exp=00000100", bus_i.correct_pc); end
  endtask

  // ctr 10 -> 11 -> 11 -> 10 -> 01 -> 00 ; predicted-taken bit after each edge
  task automatic test_counter();
    logic       tk   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       expt [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bus_i.lookup_pc = 32'h0000_0040;
    for (int i = 0; i < 5; i++) begin
      drive_upd(32'h0000_0040, tk[i], tk[i] ? 32'h100 : 32'h999, tk[i], 32'h100);
      step();
      idle();
      n_cmp++; if (bus_i.lookup_taken !== expt[i]) begin n_err++; $display("FAIL ctr_taken[%0d] got=%0h exp=%0h", i, bus_i.lookup_taken, expt[i]); end
      n_cmp++; if (bus_i.lookup_hit !== 1'b1) begin n_err++; $display("FAIL ctr_hit[%0d] got=%0h exp=1", i, bus_i.lookup_hit); end
      n_cmp++; if (bus_i.wrong_decision !== 1'b0) begin n_err++; $display("FAIL ctr_wd[%0d] got=%0h exp=0", i, bus_i.wrong_decision); end
    end
    n_cmp++; if (bus_i.lookup_target !== 32'h100) begin n_err++; $display("FAIL ctr_target_kept got=%h exp=00000100", bus_i.lookup_target); end
  endtask

  task automatic test_alias();
    drive_upd(32'h0000_0440, 1'b1, 32'h200, 1'b1, 32'h200);
    step();
    idle();
    bus_i.lookup_pc = 32'h0000_0040;
    #1;
    n_cmp++; if (bus_i.lookup_hit !== 1'b0) begin n_err++; $display("FAIL alias_old_hit got=%0h exp=0", bus_i.lookup_hit); end
    bus_i.lookup_pc = 32'h0000_0440;
    #1;
    n_cmp++; if (bus_i.lookup_hit !== 1'b1) begin n_err++; $display("FAIL alias_new_hit got=%0h exp=1", bus_i.lookup_hit); end
    n_cmp++; if (bus_i.lookup_taken !== 1'b1) begin n_err++; $display("FAIL alias_new_taken got=%0h exp=1", bus_i.lookup_taken); end
    n_cmp++; if (bus_i.lookup_target !== 32'h200) begin n_err++; $display("FAIL alias_new_target got=%h exp=00000200", bus_i.lookup_target); end
    // a single not-taken step must drop a fresh 10 entry to 01
    drive_upd(32'h0000_0440, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    idle();
    n_cmp++; if (bus_i.lookup_taken !== 1'b0) begin n_err++; $display("FAIL alias_ctr10 got=%0h exp=0", bus_i.lookup_taken); end
  endtask

  task automatic test_mispredict_nt();
    drive_upd(32'h0000_0080, 1'b1, 32'h300, 1'b1, 32'h300);
    step();
    bus_i.lookup_pc = 32'h0000_0080;
    drive_upd(32'h0000_0080, 1'b0, 32'h0, 1'b1, 32'h300);
    #1;
    n_cmp++; if (bus_i.lookup_taken !== 1'b1) begin n_err++; $display("FAIL nt_same_cycle_taken got=%0h exp=1", bus_i.lookup_taken); end
    step();
    idle();
    n_cmp++; if (bus_i.wrong_decision !== 1'b1) begin n_err++; $display("FAIL nt_wd got=%0h exp=1", bus_i.wrong_decision); end
    n_cmp++; if (bus_i.correct_pc !== 32'h84) begin n_err++; $display("FAIL nt_cpc got=%h exp=00000084", bus_i.correct_pc); end
    n_cmp++; if (bus_i.lookup_taken !== 1'b0) begin n_err++; $display("FAIL nt_after_taken got=%0h exp=0", bus_i.lookup_taken); end
    n_cmp++; if (bus_i.lookup_hit !== 1'b1) begin n_err++; $display("FAIL nt_after_hit got=%0h exp=1", bus_i.lookup_hit); end
  endtask

  task automatic test_back_to_back();
    drive_upd(32'h0000_00C0, 1'b1, 32'h400, 1'b0, 32'h0);
    step();
    n_cmp++; if (bus_i.wrong_decision !== 1'b1) begin n_err++; $display("FAIL b2b_wd0 got=%0h exp=1", bus_i.wrong_decision); end
    n_cmp++; if (bus_i.correct_pc !== 32'h400) begin n_err++; $display("FAIL b2b_cpc0 got=%h exp=00000400", bus_i.correct_pc); end
    drive_upd(32'h0000_0100, 1'b0, 32'h0, 1'b1, 32'h500);
    step();
    n_cmp++; if (bus_i.wrong_decision !== 1'b1) begin n_err++; $display("FAIL b2b_wd1 got=%0h exp=1", bus_i.wrong_decision); end
    n_cmp++; if (bus_i.correct_pc !== 32'h104) begin n_err++; $display("FAIL b2b_cpc1 got=%h exp=00000104", bus_i.correct_pc); end
    // taken in both, but target disagrees
    drive_upd(32'h0000_00C0, 1'b1, 32'h400, 1'b1, 32'h404);
    step();
    n_cmp++; if (bus_i.wrong_decision !== 1'b1) begin n_err++; $display("FAIL b2b_wd_tgt got=%0h exp=1", bus_i.wrong_decision); end
    n_cmp++; if (bus_i.correct_pc !== 32'h400) begin n_err++; $display("FAIL b2b_cpc_tgt got=%h exp=00000400", bus_i.correct_pc); end
    // pc+4 wraps; not-taken miss leaves the array alone
    drive_upd(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h10);
    step();
    idle();
    n_cmp++; if (bus_i.correct_pc !== 32'h0) begin n_err++; $display("FAIL wrap_cpc got=%h exp=00000000", bus_i.correct_pc); end
    bus_i.lookup_pc = 32'hFFFF_FFFC;
    #1;
    n_cmp++; if (bus_i.lookup_hit !== 1'b0) begin n_err++; $display("FAIL nt_miss_noalloc got=%0h exp=0", bus_i.lookup_hit); end
    step();
    n_cmp++; if (bus_i.wrong_decision !== 1'b0) begin n_err++; $display("FAIL b2b_wd_end got=%0h exp=0", bus_i.wrong_decision); end
    n_cmp++; if (bus_i.correct_pc !== 32'h0) begin n_err++; $display("FAIL b2b_cpc_hold got=%h exp=00000000", bus_i.correct_pc); end
  endtask

  task automatic test_stats_and_async_reset();
    logic [15:0] exp_b, exp_m;
`ifdef BTB_STATS_EN
    exp_b = 16'd5; exp_m = 16'd2;
`else
    exp_b = 16'd0; exp_m = 16'd0;
`endif
    @(negedge CLK);
    RST = 1'b1;
    #1;
    RST = 1'b0;
    step();
    drive_upd(32'h10, 1'b1, 32'h500, 1'b1, 32'h500); step();
    drive_upd(32'h14, 1'b1, 32'h600, 1'b0, 32'h0);   step();
    drive_upd(32'h10, 1'b0, 32'h0,   1'b0, 32'h0);   step();
    drive_upd(32'h18, 1'b0, 32'h0,   1'b0, 32'h0);   step();
    drive_upd(32'h10, 1'b1, 32'h500, 1'b1, 32'h504); step();
    n_cmp++; if (bus_i.branch_count !== exp_b) begin n_err++; $display("FAIL stats_branch got=%0d exp=%0d", bus_i.branch_count, exp_b); end
    n_cmp++; if (bus_i.mispredict_count !== exp_m) begin n_err++; $display("FAIL stats_mis got=%0d exp=%0d", bus_i.mispredict_count, exp_m); end
    n_cmp++; if (bus_i.wrong_decision !== 1'b1) begin n_err++; $display("FAIL stats_wd got=%0h exp=1", bus_i.wrong_decision); end
    n_cmp++; if (bus_i.correct_pc !== 32'h500) begin n_err++; $display("FAIL stats_cpc got=%h exp=00000500", bus_i.correct_pc); end
    bus_i.lookup_pc = 32'h14;
    #1;
    n_cmp++; if (bus_i.lookup_hit !== 1'b1) begin n_err++; $display("FAIL stats_pre_rst_hit got=%0h exp=1", bus_i.lookup_hit); end
    // reset between clock edges, update still asserted
    #1;
    RST = 1'b1;
    #1;
    n_cmp++; if (bus_i.wrong_decision !== 1'b0) begin n_err++; $display("FAIL arst_wd got=%0h exp=0", bus_i.wrong_decision); end
    n_cmp++; if (bus_i.correct_pc !== 32'd0) begin n_err++; $display("FAIL arst_cpc got=%h exp=0", bus_i.correct_pc); end
    n_cmp++; if (bus_i.lookup_hit !== 1'b0) begin n_err++; $display("FAIL arst_hit got=%0h exp=0", bus_i.lookup_hit); end
    n_cmp++; if (bus_i.lookup_target !== 32'd0) begin n_err++; $display("FAIL arst_target got=%h exp=0", bus_i.lookup_target); end
    n_cmp++; if (bus_i.branch_count !== 16'd0) begin n_err++; $display("FAIL arst_branch got=%0d exp=0", bus_i.branch_count); end
    n_cmp++; if (bus_i.mispredict_count !== 16'd0) begin n_err++; $display("FAIL arst_mis got=%0d exp=0", bus_i.mispredict_count); end
    step();
    idle();
    @(negedge CLK);
    RST = 1'b0;
    step();
    n_cmp++; if (bus_i.lookup_hit !== 1'b0) begin n_err++; $display("FAIL arst_release_hit got=%0h exp=0", bus_i.lookup_hit); end
    n_cmp++; if (bus_i.wrong_decision !== 1'b0) begin n_err++; $display("FAIL arst_release_wd got=%0h exp=0", bus_i.wrong_decision); end
  endtask

  initial begin
    RST = 1'b1;
    bus_i.lookup_pc = 32'd0;
    idle();
    test_reset();
    test_allocate();
    test_counter();
    test_alias();
    test_mispredict_nt();
    test_back_to_back();
    test_stats_and_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
